decoder_n_reg: RTL and testbench

Parametrised, registered N-to-M one-hot decoder. It is the successor to the fixed 3-to-8 combinational decoder used for register and unit select in the CPU datapath. It adds a single-entry valid/ready output register, out-of-range and unknown-select error reporting, selectable hold or clear behaviour after consumption, and a saturating error counter. It sits between the instruction decode stage and register-file and unit write enables.

---
 rtl/decoder_n_reg.sv | 100 ++++++++++
 tb/tb_decoder_n_reg.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_n_reg.sv
// Registered N-to-M one-hot decoder with a single-entry valid/ready output
// stage, range/unknown-select error flag and a saturating error counter.
module decoder_n_reg #(
  parameter int SEL_W     = 3,
  parameter int NUM_OUT   = 8,
  parameter int HOLD      = 1,
  parameter int ERR_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_OUT-1:0]   out_onehot,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_valid/in_ready accept a select; out_valid/out_ready consume a result.
  // out_valid never drops without a consume (or reset), and the held result
  // stays stable while stalled.

  localparam logic [SEL_W:0]     NUM_OUT_W = (SEL_W+1)'(NUM_OUT);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic                 out_valid_q;
  logic [NUM_OUT-1:0]   onehot_q;
  logic                 err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic                 accept;
  logic                 consume;
  logic                 in_range;
  logic                 sel_unknown;
  logic                 dec_err;
  logic [NUM_OUT-1:0]   dec_onehot;
  logic [ERR_CNT_W-1:0] cnt_nxt;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

  // The unknown test only resolves to 1 in simulation; synthesis sees 0.
  assign sel_unknown = ((^sel) === 1'bx);
  assign in_range    = ({1'b0, sel} < NUM_OUT_W);
  assign dec_err     = sel_unknown || !in_range;

  always_comb begin
    dec_onehot = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      dec_onehot[k] = !dec_err && (sel == SEL_W'(k));
    end
  end

  always_comb begin
    cnt_nxt = err_cnt_q;
    if (err_clr) begin
      cnt_nxt = (accept && dec_err) ? ERR_CNT_W'(1) : '0;
    end else if (accept && dec_err && (err_cnt_q != CNT_MAX)) begin
      cnt_nxt = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      onehot_q    <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_cnt_q <= cnt_nxt;
      if (accept) begin
        // Also covers simultaneous consume: new result replaces the old one.
        out_valid_q <= 1'b1;
        onehot_q    <= dec_onehot;
        err_q       <= dec_err;
      end else if (consume) begin
        out_valid_q <= 1'b0;
        err_q       <= 1'b0;
        if (HOLD == 0) begin
          onehot_q <= '0;
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_onehot = onehot_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

  a_onehot : assert property (@(posedge clk) disable iff (rst) $countones(onehot_q) <= 1);
  a_err_zero : assert property (@(posedge clk) disable iff (rst) err_q |-> (onehot_q == '0));
  a_err_valid : assert property (@(posedge clk) disable iff (rst) !out_valid_q |-> !err_q);

endmodule

// File: tb/tb_decoder_n_reg.sv
// Bench for decoder_n_reg: one default instance (8 outputs, HOLD=1, 4-bit counter)
// and one narrow instance (5 outputs, HOLD=0, 2-bit counter) sharing all inputs.
module tb_decoder_n_reg;

  typedef enum logic [2:0] {M_RST, M_ACC, M_CONS, M_STALL, M_IDLE} mode_e;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] sel;
  logic       out_ready;
  logic       err_clr;

  logic       in_ready_a, out_valid_a, err_a;
  logic [7:0] oh_a;
  logic [3:0] cnt_a_dut;
  logic       in_ready_b, out_valid_b, err_b;
  logic [4:0] oh_b;
  logic [1:0] cnt_b_dut;

  logic [8:0] exp_qa[$];
  logic [5:0] exp_qb[$];
  logic [3:0] cnt_a;
  logic [1:0] cnt_b;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  decoder_n_reg #(.SEL_W(3), .NUM_OUT(8), .HOLD(1), .ERR_CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .sel(sel),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_onehot(oh_a), .err(err_a),
    .err_cnt(cnt_a_dut), .err_clr(err_clr)
  );

  decoder_n_reg #(.SEL_W(3), .NUM_OUT(5), .HOLD(0), .ERR_CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .sel(sel),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_onehot(oh_b), .err(err_b),
    .err_cnt(cnt_b_dut), .err_clr(err_clr)
  );

  function automatic logic [8:0] model_a(input logic [2:0] s);
    logic [7:0] one;
    if ((^s) === 1'bx) return {1'b1, 8'h00};
    one = 8'h01;
    return {1'b0, one << s};
  endfunction

  function automatic logic [5:0] model_b(input logic [2:0] s);
    logic [4:0] one;
    if ((^s) === 1'bx) return {1'b1, 5'b0};
    if (s >= 3'd5) return {1'b1, 5'b0};
    one = 5'b00001;
    return {1'b0, one << s};
  endfunction

  // One clock: record expectations from the inputs set up before the edge,
  // then check both instances half a cycle after the edge.
  task automatic tick();
    logic       acc, cons;
    logic [8:0] ea, pa;
    logic [5:0] eb, pb;
    mode_e      mode;
    ea = '0; eb = '0;
    #1;
    acc = in_valid && in_ready_a && !rst;
    cons = out_valid_a && out_ready;
    pa = {err_a, oh_a};
    pb = {err_b, oh_b};
    if (rst) begin
      exp_qa.delete(); exp_qb.delete();
      cnt_a = '0; cnt_b = '0;
      mode = M_RST;
    end else begin
      mode = acc ? M_ACC : cons ? M_CONS : out_valid_a ? M_STALL : M_IDLE;
      if (acc) begin
        ea = model_a(sel); eb = model_b(sel);
        exp_qa.push_back(ea); exp_qb.push_back(eb);
      end
      if (err_clr) cnt_a = (acc && ea[8]) ? 4'd1 : 4'd0;
      else if (acc && ea[8] && cnt_a != 4'hf) cnt_a = cnt_a + 4'd1;
      if (err_clr) cnt_b = (acc && eb[5]) ? 2'd1 : 2'd0;
      else if (acc && eb[5] && cnt_b != 2'd3) cnt_b = cnt_b + 2'd1;
    end
    @(posedge clk);
    @(negedge clk);
    case (mode)
      M_RST: begin
        checks++;
        if ({out_valid_a, err_a, oh_a} !== 10'h0 || {out_valid_b, err_b, oh_b} !== 7'h0) begin
          errors++;
          $display("FAIL reset_out: a=%b/%b/%h b=%b/%b/%h want all zero",
                   out_valid_a, err_a, oh_a, out_valid_b, err_b, oh_b);
        end
      end
      M_ACC: begin
        checks++;
        if (exp_qa.size() == 0 || exp_qb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: got %0d/%0d entries want 1", exp_qa.size(), exp_qb.size());
        end else begin
          ea = exp_qa.pop_front();
          eb = exp_qb.pop_front();
          if ({out_valid_a, err_a, oh_a} !== {1'b1, ea}) begin
            errors++;
            $display("FAIL decode_a: got v=%b e=%b oh=%h want v=1 e=%b oh=%h", out_valid_a, err_a, oh_a, ea[8], ea[7:0]);
          end
          checks++;
          if ({out_valid_b, err_b, oh_b} !== {1'b1, eb}) begin
            errors++;
            $display("FAIL decode_b: got v=%b e=%b oh=%b want v=1 e=%b oh=%b", out_valid_b, err_b, oh_b, eb[5], eb[4:0]);
          end
        end
      end
      M_STALL: begin
        checks++;
        if ({out_valid_a, err_a, oh_a} !== {1'b1, pa} || {out_valid_b, err_b, oh_b} !== {1'b1, pb}) begin
          errors++;
          $display("FAIL stall_stable: a=%b/%h b=%b/%h want a=1/%h b=1/%h",
                   out_valid_a, {err_a, oh_a}, out_valid_b, {err_b, oh_b}, pa, pb);
        end
      end
      M_CONS: begin
        checks++;
        if ({out_valid_a, err_a, oh_a} !== {2'b00, pa[7:0]} || {out_valid_b, err_b, oh_b} !== 7'h0) begin
          errors++;
          $display("FAIL consume: a=%b/%b/%h b=%b/%b/%b want a=0/0/%h b=0/0/00000",
                   out_valid_a, err_a, oh_a, out_valid_b, err_b, oh_b, pa[7:0]);
        end
      end
      default: begin
        checks++;
        if ({out_valid_a, err_a, oh_a} !== {1'b0, pa} || {out_valid_b, err_b, oh_b} !== {1'b0, pb}) begin
          errors++;
          $display("FAIL idle_stable: a=%b/%h b=%b/%h want a=0/%h b=0/%h",
                   out_valid_a, {err_a, oh_a}, out_valid_b, {err_b, oh_b}, pa, pb);
        end
      end
    endcase
    checks++;
    if (cnt_a_dut !== cnt_a || cnt_b_dut !== cnt_b) begin
      errors++;
      $display("FAIL err_cnt: got a=%0d b=%0d want a=%0d b=%0d", cnt_a_dut, cnt_b_dut, cnt_a, cnt_b);
    end
    checks++;
    if (in_ready_a !== (!out_valid_a || out_ready) || in_ready_b !== (!out_valid_b || out_ready)) begin
      errors++;
      $display("FAIL in_ready: got a=%b b=%b with out_ready=%b", in_ready_a, in_ready_b, out_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; sel = '0; out_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (cnt_a_dut !== 4'd0 || cnt_b_dut !== 2'd0 || in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: cnt_a=%0d cnt_b=%0d in_ready=%b want 0 0 1", cnt_a_dut, cnt_b_dut, in_ready_a);
    end
  endtask

  task automatic test_decode_all();
    logic [7:0] want;
    in_valid = 1'b1; out_ready = 1'b1;
    want = 8'h01;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      tick();
      checks++;
      if (out_valid_a !== 1'b1 || oh_a !== want || err_a !== 1'b0 || cnt_a_dut !== 4'd0) begin
        errors++;
        $display("FAIL decode_seq: sel=%0d got v=%b oh=%h e=%b cnt=%0d want v=1 oh=%h e=0 cnt=0",
                 s, out_valid_a, oh_a, err_a, cnt_a_dut, want);
      end
      want = want << 1;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_out_of_range();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; sel = 3'd6;
    tick();
    checks++;
    if (oh_b !== 5'b00000 || err_b !== 1'b1 || cnt_b_dut !== 2'd1) begin
      errors++;
      $display("FAIL range_hi: got oh=%b e=%b cnt=%0d want 00000 1 1", oh_b, err_b, cnt_b_dut);
    end
    sel = 3'd2;
    tick();
    checks++;
    if (oh_b !== 5'b00100 || err_b !== 1'b0) begin
      errors++;
      $display("FAIL range_ok: got oh=%b e=%b want 00100 0", oh_b, err_b);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    in_valid = 1'b1; out_ready = 1'b1; sel = 3'd3;
    tick();
    out_ready = 1'b0; sel = 3'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (in_ready_a !== 1'b0 || oh_a !== 8'h08 || out_valid_a !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got rdy=%b oh=%h v=%b want 0 08 1", i, in_ready_a, oh_a, out_valid_a);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (oh_a !== 8'h20) begin
      errors++;
      $display("FAIL stall_release: got %h want 20", oh_a);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    in_valid = 1'b1; out_ready = 1'b1; sel = 3'd4;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (oh_a !== 8'h10 || out_valid_a !== 1'b0 || oh_b !== 5'b0) begin
      errors++;
      $display("FAIL hold_mode: got a_oh=%h a_v=%b b_oh=%b want 10 0 00000", oh_a, out_valid_a, oh_b);
    end
  endtask

  task automatic test_err_sat();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sel = 3'($urandom_range(5, 7));
      tick();
    end
    checks++;
    if (cnt_b_dut !== 2'd3) begin
      errors++;
      $display("FAIL err_saturate: got %0d want 3", cnt_b_dut);
    end
    err_clr = 1'b1; sel = 3'd6;
    tick();
    err_clr = 1'b0;
    checks++;
    if (cnt_b_dut !== 2'd1) begin
      errors++;
      $display("FAIL err_clr_acc: got %0d want 1", cnt_b_dut);
    end
    sel = 3'bx0x;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; sel = 3'd7;
    tick(); tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    checks++;
    if (cnt_b_dut !== 2'd2 || out_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got cnt=%0d v=%b want 2 1", cnt_b_dut, out_valid_b);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid_b !== 1'b0 || oh_a !== 8'h0 || err_b !== 1'b0 || cnt_b_dut !== 2'd0 || in_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got v=%b oh=%h e=%b cnt=%0d rdy=%b want 0 00 0 0 1",
               out_valid_b, oh_a, err_b, cnt_b_dut, in_ready_b);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      sel       = 3'($urandom_range(0, 7));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    tick();
  endtask

  initial begin
    cnt_a = '0; cnt_b = '0;
    rst = 1'b1; in_valid = 1'b0; sel = '0; out_ready = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_decode_all();
    test_out_of_range();
    test_stall();
    test_hold();
    test_err_sat();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
